// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite slave front end.
// Build option AXIL_SLVERR_EN: decode failures answer SLVERR instead of OKAY.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_t;

  // Encoding of the arbiter's last-grant flop.
  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  // Response for an access whose decode result is addr_ok.
  function automatic resp_t dec_resp(input logic addr_ok);
`ifdef AXIL_SLVERR_EN
    return addr_ok ? RESP_OKAY : RESP_SLVERR;
`else
    return RESP_OKAY;
`endif
  endfunction

endpackage

// File: rtl/axil_slave_ctrl.sv
// AXI4-Lite slave: write/read FSMs serialised onto one register port via a 1-bit arbiter.
// Build option AXIL_SLVERR_EN selects SLVERR (vs silent OKAY) for decode failures.
module axil_slave_ctrl
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ADDR_W-1:0] dec_addr,
  input  logic              dec_addr_valid,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [STRB_W-1:0] reg_wstrb,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic              aw_got, w_got, aw_got_d, w_got_d;
  logic              awready_q, wready_q, arready_q;
  logic [ADDR_W-1:0] aw_lat, ar_lat;
  logic [DATA_W-1:0] w_lat;
  logic [STRB_W-1:0] ws_lat;
  logic [DATA_W-1:0] rdata_q;
  resp_t             bresp_q, rresp_q;
  logic              last_grant;
  logic              gnt_wr, gnt_rd;
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = s_awvalid & awready_q;
  assign w_hs  = s_wvalid  & wready_q;
  assign ar_hs = s_arvalid & arready_q;
  assign b_hs  = s_bvalid  & s_bready;
  assign r_hs  = s_rvalid  & s_rready;

  // On a tie the side not granted last wins; last_grant resets so that
  // read wins the first tie after reset.
  always_comb begin
    gnt_wr = (wr_state == W_EXEC) &&
             ((rd_state != R_EXEC) || (last_grant == GNT_RD));
    gnt_rd = (rd_state == R_EXEC) && !gnt_wr;
  end

  assign dec_addr  = gnt_rd ? ar_lat : aw_lat;
  assign reg_wr_en = gnt_wr & dec_addr_valid;
  assign reg_rd_en = gnt_rd & dec_addr_valid;
  assign reg_wdata = w_lat;
  assign reg_wstrb = ws_lat;

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = (wr_state == W_RESP);
  assign s_rvalid  = (rd_state == R_RESP);
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  always_comb begin
    wr_next  = wr_state;
    aw_got_d = aw_got | aw_hs;
    w_got_d  = w_got  | w_hs;
    case (wr_state)
      W_IDLE: if (aw_got_d && w_got_d) wr_next = W_EXEC;
      W_EXEC: if (gnt_wr) wr_next = W_RESP;
      W_RESP: if (b_hs) begin
        wr_next  = W_IDLE;
        aw_got_d = 1'b0;
        w_got_d  = 1'b0;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)  rd_next = R_EXEC;
      R_EXEC:  if (gnt_rd) rd_next = R_RESP;
      R_RESP:  if (r_hs)   rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state   <= W_IDLE;
      rd_state   <= R_IDLE;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      aw_lat     <= '0;
      ar_lat     <= '0;
      w_lat      <= '0;
      ws_lat     <= '0;
      rdata_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      last_grant <= GNT_WR;
    end else begin
      wr_state  <= wr_next;
      rd_state  <= rd_next;
      aw_got    <= aw_got_d;
      w_got     <= w_got_d;
      // Each ready is up only while its channel still owes a beat in idle.
      awready_q <= (wr_next == W_IDLE) && !aw_got_d;
      wready_q  <= (wr_next == W_IDLE) && !w_got_d;
      arready_q <= (rd_next == R_IDLE);
      if (aw_hs) aw_lat <= s_awaddr;
      if (ar_hs) ar_lat <= s_araddr;
      if (w_hs) begin
        w_lat  <= s_wdata;
        ws_lat <= s_wstrb;
      end
      if (gnt_wr) bresp_q <= dec_resp(dec_addr_valid);
      if (gnt_rd) begin
        rresp_q <= dec_resp(dec_addr_valid);
        rdata_q <= dec_addr_valid ? reg_rdata : '0;
      end
      if (gnt_wr || gnt_rd) last_grant <= gnt_wr ? GNT_WR : GNT_RD;
    end
  end

endmodule

// File: tb/tb_axil_slave_ctrl.sv
// Directed bench for axil_slave_ctrl with a small behavioural address decoder.
module tb_axil_slave_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_addr_valid;
  logic              reg_wr_en;
  logic [DATA_W-1:0] reg_wdata;
  logic [STRB_W-1:0] reg_wstrb;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rdata;

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  int w0, r0, w1;

  axil_slave_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .dec_addr(dec_addr), .dec_addr_valid(dec_addr_valid),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata)
  );

  always #5 aclk = ~aclk;

  // Decoder model: eight word registers at 0x00..0x1C.
  always_comb begin
    dec_addr_valid = (dec_addr[1:0] == 2'b00) && (dec_addr < 32'h20);
    case (dec_addr)
      32'h0C:  reg_rdata = 32'h1234_5678;
      32'h04:  reg_rdata = 32'hA5A5_0004;
      default: reg_rdata = 32'hBAD0_0000 | dec_addr;
    endcase
  end

  always @(negedge aclk) begin
    if (reg_wr_en) wr_cnt <= wr_cnt + 1;
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (reg_wr_en && reg_rd_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;

    // Reset state
    #3;
    chk("rst_readys", {s_awready, s_wready, s_arready}, 3'b000);
    chk("rst_valids", {s_bvalid, s_rvalid}, 2'b00);
    chk("rst_strobes", {reg_wr_en, reg_rd_en}, 2'b00);
    chk("rst_resp", {s_bresp, s_rresp}, 4'b0000);
    chk("rst_rdata", s_rdata, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
    chk("post_rst_readys", {s_awready, s_wready, s_arready}, 3'b111);

    // Aligned write, AW and W together
    s_awaddr = 32'h08; s_awvalid = 1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("w1_strobe", reg_wr_en, 1);
    chk("w1_wdata", {reg_wstrb, reg_wdata}, {4'hF, 32'hDEAD_BEEF});
    chk("w1_dec_addr", dec_addr, 32'h08);
    chk("w1_ready_low", {s_awready, s_wready, s_bvalid}, 3'b000);
    tick();
    chk("w1_bvalid", {s_bvalid, s_bresp, reg_wr_en}, {1'b1, 2'b00, 1'b0});
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("w1_done", {s_bvalid, s_awready, s_wready}, 3'b011);
    chk("w1_count", wr_cnt, 1);

    // W three cycles before AW, bready held high early
    s_bready = 1;
    s_wdata = 32'h1122_3344; s_wstrb = 4'h3; s_wvalid = 1;
    tick();
    s_wvalid = 0;
    chk("w2_wready_drop", {s_wready, s_awready}, 2'b01);
    w0 = wr_cnt;
    tick(); tick();
    chk("w2_no_exec", {wr_cnt - w0, 31'd0, s_bvalid}, 0);
    s_awaddr = 32'h00; s_awvalid = 1;
    tick();
    s_awvalid = 0;
    chk("w2_strobe", {reg_wr_en, reg_wstrb, reg_wdata}, {1'b1, 4'h3, 32'h1122_3344});
    tick();
    chk("w2_bvalid", {s_bvalid, s_bresp}, {1'b1, 2'b00});
    tick();
    s_bready = 0;
    chk("w2_done", {s_bvalid, s_wready}, 2'b01);

    // Read with rready held low
    s_araddr = 32'h0C; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    chk("r1_strobe", {s_arready, reg_rd_en, dec_addr}, {1'b0, 1'b1, 32'h0C});
    tick();
    chk("r1_rvalid", {s_rvalid, s_rdata, s_rresp}, {1'b1, 32'h1234_5678, 2'b00});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r1_hold", {s_rvalid, s_rdata, s_rresp}, {1'b1, 32'h1234_5678, 2'b00});
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("r1_done", {s_rvalid, s_arready}, 2'b01);

    // Decode failures: unaligned write, out-of-range read
    w0 = wr_cnt;
    s_awaddr = 32'h02; s_awvalid = 1; s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    chk("werr_bresp", {s_bvalid, s_bresp}, {1'b1, EXP_ERR});
    chk("werr_no_strobe", wr_cnt, w0);
    s_bready = 1; tick(); s_bready = 0;
    r0 = rd_cnt;
    s_araddr = 32'h40; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    tick();
    chk("rerr_rresp", {s_rvalid, s_rresp, s_rdata}, {1'b1, EXP_ERR, 32'h0});
    chk("rerr_no_strobe", rd_cnt, r0);
    s_rready = 1; tick(); s_rready = 0;

    // Contention straight after reset: read wins, write follows
    do_reset();
    w0 = wr_cnt; r0 = rd_cnt;
    s_awaddr = 32'h00; s_awvalid = 1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1;
    s_araddr = 32'h04; s_arvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("arb_rd_first", {reg_rd_en, reg_wr_en, dec_addr}, {1'b1, 1'b0, 32'h04});
    tick();
    chk("arb_wr_second", {reg_wr_en, reg_rd_en, dec_addr}, {1'b1, 1'b0, 32'h00});
    chk("arb_rdata", {s_rvalid, s_rdata}, {1'b1, 32'hA5A5_0004});
    tick();
    chk("arb_bvalid", {s_bvalid, s_bresp}, {1'b1, 2'b00});
    s_bready = 1; s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
    chk("arb_done", {s_bvalid, s_rvalid}, 2'b00);
    chk("arb_counts", {wr_cnt - w0, rd_cnt - r0}, {32'd1, 32'd1});

    // Reset while in W_RESP with bready low
    w0 = wr_cnt;
    s_awaddr = 32'h10; s_awvalid = 1; s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    chk("rstmid_bvalid", s_bvalid, 1);
    w1 = wr_cnt;
    chk("rstmid_strobe", w1 - w0, 1);
    #2 aresetn = 0;
    #1;
    chk("rstmid_immediate", {s_bvalid, s_awready, s_wready}, 3'b000);
    @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1;
    tick();
    chk("rstmid_readys", {s_awready, s_wready, s_arready, s_bvalid}, 4'b1110);
    tick(); tick(); tick();
    chk("rstmid_no_strobe", wr_cnt, w1);
    chk("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
